// File: rtl/uart_frame_pkg.sv
// Shared constants, FSM state encoding and checksum helper for the UART frame decoder.
// Frames are SYNC, ADDR, DATA, CHK with CHK = seed ^ ADDR ^ DATA.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CHK_SEED  = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } frame_state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
    return CHK_SEED ^ addr ^ data;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter: expired is a combinational one-cycle flag that is true
// when the edge it is sampled at is the TIMEOUT_CYC-th idle edge since the last clear.
module frame_timer #(
  parameter int TIMEOUT_CYC = 12_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A byte at the expiry edge clears the count and suppresses the expiry.
  assign expired = run && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !run || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/ADDR/DATA/CHK frames from the UART byte strobe and writes a register bank.
// All outputs registered, one edge after the CHK byte or timeout; no backpressure, every strobe is consumed.
module uart_frame_decoder #(
  parameter int NREGS       = 4,
  parameter int TIMEOUT_CYC = 12_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               received,
  output logic [8*NREGS-1:0] regs,
  output logic               wr_strobe,
  output logic [7:0]         wr_addr,
  output logic               frame_err,
  output logic [7:0]         err_count
);

  import uart_frame_pkg::*;

  localparam logic [8:0] NREGS_W = 9'(NREGS);

  frame_state_t state_q, state_d;
  logic [7:0]   addr_q, addr_d;
  logic [7:0]   data_q, data_d;
  logic [7:0]   regs_q [NREGS];
  logic [7:0]   regs_d [NREGS];
  logic         wr_strobe_q, wr_strobe_d;
  logic [7:0]   wr_addr_q, wr_addr_d;
  logic         frame_err_q, frame_err_d;
  logic [7:0]   err_count_q, err_count_d;
  logic         tmr_expired;
  logic         addr_in_range;

  frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (received),
    .run     (state_q != S_IDLE),
    .expired (tmr_expired)
  );

  assign addr_in_range = {1'b0, addr_q} < NREGS_W;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    if (received) begin
      case (state_q)
        S_IDLE: if (rx_data == SYNC_BYTE) state_d = S_ADDR;
        S_ADDR: begin
          addr_d  = rx_data;
          state_d = S_DATA;
        end
        S_DATA: begin
          data_d  = rx_data;
          state_d = S_CHK;
        end
        default: begin
          state_d = S_IDLE;
          if (rx_data == frame_chk(addr_q, data_q) && addr_in_range) begin
            for (int k = 0; k < NREGS; k++) begin
              if (addr_q == 8'(k)) regs_d[k] = data_q;
            end
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      endcase
    end else if (tmr_expired) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end
    err_count_d = err_count_q;
    if (frame_err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_pack
    assign regs[8*k +: 8] = regs_q[k];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder with NREGS=4, TIMEOUT_CYC=16.
module tb_uart_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        received;
  logic [31:0] regs;
  logic        wr_strobe;
  logic [7:0]  wr_addr;
  logic        frame_err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_frame_decoder #(.NREGS(4), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .received  (received),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] frame;
    logic        exp_wr;
    logic        exp_err;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_cnt;
    logic [31:0] exp_regs;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one byte at the current falling edge; returns at the next falling edge.
  task automatic put(input logic [7:0] b);
    rx_data  = b;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f);
    put(f[31:24]);
    put(f[23:16]);
    put(f[15:8]);
    put(f[7:0]);
  endtask

  initial begin
    int early_err;
    int pulses;
    int cnt_bad;
    int strobes;

    vecs[0] = '{32'hA5013C98, 1'b1, 1'b0, 8'h01, 8'd0, 32'h00003C00};
    vecs[1] = '{32'hA502FF00, 1'b0, 1'b1, 8'h01, 8'd1, 32'h00003C00};
    vecs[2] = '{32'hA502FF58, 1'b1, 1'b0, 8'h02, 8'd1, 32'h00FF3C00};
    vecs[3] = '{32'hA50711B3, 1'b0, 1'b1, 8'h02, 8'd2, 32'h00FF3C00};
    vecs[4] = '{32'hA5038026, 1'b1, 1'b0, 8'h03, 8'd2, 32'h80FF3C00};
    vecs[5] = '{32'hA5A50000, 1'b0, 1'b1, 8'h03, 8'd3, 32'h80FF3C00};
    vecs[6] = '{32'hA50001A4, 1'b1, 1'b0, 8'h00, 8'd3, 32'h80FF3C01};
    vecs[7] = '{32'hA5090000, 1'b0, 1'b1, 8'h00, 8'd4, 32'h80FF3C01};

    rst      = 1'b1;
    received = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_regs", regs, 32'h0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].frame);
      check($sformatf("v%0d_wr_strobe", i), {31'd0, wr_strobe}, {31'd0, vecs[i].exp_wr});
      check($sformatf("v%0d_frame_err", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_wr_addr", i), {24'd0, wr_addr}, {24'd0, vecs[i].exp_addr});
      check($sformatf("v%0d_err_count", i), {24'd0, err_count}, {24'd0, vecs[i].exp_cnt});
      check($sformatf("v%0d_regs", i), regs, vecs[i].exp_regs);
      @(negedge clk);
      check($sformatf("v%0d_strobe_drop", i), {31'd0, wr_strobe}, 32'd0);
      check($sformatf("v%0d_err_drop", i), {31'd0, frame_err}, 32'd0);
    end

    // Two frames on consecutive cycles with no gap.
    send_frame(32'hA50111B5);
    check("b2b1_wr_strobe", {31'd0, wr_strobe}, 32'd1);
    check("b2b1_wr_addr", {24'd0, wr_addr}, 32'd1);
    send_frame(32'hA5022285);
    check("b2b2_wr_strobe", {31'd0, wr_strobe}, 32'd1);
    check("b2b2_wr_addr", {24'd0, wr_addr}, 32'd2);
    check("b2b_regs", regs, 32'h80221101);
    @(negedge clk);

    // Timeout: A5 00 then silence; error must appear only after edge E+16.
    put(8'hA5);
    put(8'h00);
    early_err = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (frame_err) early_err++;
    end
    check("to_no_early_err", early_err, 0);
    @(negedge clk);
    check("to_frame_err", {31'd0, frame_err}, 32'd1);
    check("to_err_count", {24'd0, err_count}, 32'd5);
    @(negedge clk);
    check("to_err_drop", {31'd0, frame_err}, 32'd0);
    send_frame(32'hA50055F0);
    check("to_recover_wr", {31'd0, wr_strobe}, 32'd1);
    check("to_recover_regs", regs, 32'h80221155);
    @(negedge clk);

    // Byte arriving exactly at the expiry edge wins.
    put(8'hA5);
    put(8'h00);
    repeat (15) @(negedge clk);
    put(8'h77);
    check("edge_byte_no_err", {31'd0, frame_err}, 32'd0);
    check("edge_byte_cnt", {24'd0, err_count}, 32'd5);
    put(8'hD2);
    check("edge_byte_wr", {31'd0, wr_strobe}, 32'd1);
    check("edge_byte_regs", regs, 32'h80221177);
    @(negedge clk);

    // Idle garbage is dropped silently and does not start the timer.
    put(8'h00);
    put(8'hFF);
    put(8'h13);
    strobes = 0;
    early_err = 0;
    for (int i = 0; i < 24; i++) begin
      if (frame_err) early_err++;
      if (wr_strobe) strobes++;
      @(negedge clk);
    end
    check("idle_no_err", early_err, 0);
    check("idle_no_wr", strobes, 0);
    check("idle_err_count", {24'd0, err_count}, 32'd5);
    check("idle_regs", regs, 32'h80221177);

    // Reset mid-frame, then a non-sync byte.
    put(8'hA5);
    put(8'h03);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_regs", regs, 32'h0);
    check("mrst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("mrst_err_count", {24'd0, err_count}, 32'd0);
    put(8'h44);
    early_err = 0;
    strobes = 0;
    for (int i = 0; i < 24; i++) begin
      if (frame_err) early_err++;
      if (wr_strobe) strobes++;
      @(negedge clk);
    end
    check("mrst_no_err", early_err, 0);
    check("mrst_no_wr", strobes, 0);

    // Reset in the same cycle as a sync byte: the byte must be ignored.
    rst      = 1'b1;
    rx_data  = 8'hA5;
    received = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    received = 1'b0;
    put(8'h00);
    put(8'h11);
    put(8'hB4);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      if (wr_strobe) strobes++;
      @(negedge clk);
    end
    check("rst_byte_no_wr", strobes, 0);
    check("rst_byte_regs", regs, 32'h0);

    // Saturation: 260 bad-checksum frames.
    pulses  = 0;
    cnt_bad = 0;
    for (int i = 1; i <= 260; i++) begin
      int e;
      send_frame(32'hA5000000);
      e = (i > 255) ? 255 : i;
      if (frame_err) pulses++;
      if (int'(err_count) != e) cnt_bad++;
      @(negedge clk);
    end
    check("sat_pulses", pulses, 260);
    check("sat_count_track", cnt_bad, 0);
    check("sat_err_count", {24'd0, err_count}, 32'd255);
    check("sat_regs", regs, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Byte-stream consumer sitting directly downstream of the UART receiver. It takes the receiver's 8-bit data and one-cycle `received` strobe, assembles 4-byte command frames (sync, address, data, checksum), validates them, and writes a small bank of 8-bit registers. The registers drive LEDs or other board-level controls. Malformed and stalled frames are dropped and counted.

## Interface
- `NREGS`, 4: number of 8-bit registers; valid addresses are 0..NREGS-1 (1..256).
- `TIMEOUT_CYC`, 12_000: inter-byte timeout in clock cycles (1 ms at 12 MHz); must be ≥ 2.
- `clk` in 1: system clock, single domain.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte; valid only in the cycle `received` is high.
- `received` in 1: byte strobe; every high cycle counts as one byte.
- `regs` out 8*NREGS: register bank, register k at bits [8k+7:8k].
- `wr_strobe` out 1: one-cycle pulse when a register is written.
- `wr_addr` out 8: address of the last write; holds between writes.
- `frame_err` out 1: one-cycle pulse per rejected frame.
- `err_count` out 8: rejected-frame count, saturating at 255.

## Operation
- Frame format: `SYNC=8'hA5`, `ADDR`, `DATA`, `CHK`.
- Checksum rule: `CHK == 8'hA5 ^ ADDR ^ DATA`, computed bytewise XOR.
- FSM states: `S_IDLE`, `S_ADDR`, `S_DATA`, `S_CHK`.
  - S_IDLE: on a byte equal to A5, go to S_ADDR. Any other byte is discarded silently, with no error.
  - S_ADDR: latch ADDR and go to S_DATA. A5 is accepted as an address; the decoder does not resync mid-frame.
  - S_DATA: latch DATA and go to S_CHK.
  - S_CHK: the byte is CHK; always return to S_IDLE.
    - If the checksum matches and ADDR < NREGS: write `regs[ADDR] <= DATA`, pulse `wr_strobe`, and set `wr_addr <= ADDR`.
    - Otherwise (bad checksum, or ADDR ≥ NREGS): pulse `frame_err` and increment `err_count`. A bad checksum takes precedence, but either produces exactly one error pulse.
- Timeout:
  - The counter clears on every accepted byte.
  - It increments on each cycle without `received` while the FSM is outside S_IDLE.
  - It is held at 0 in S_IDLE.
  - When the counter reaches TIMEOUT_CYC: return to S_IDLE, pulse `frame_err`, increment `err_count`.
- `err_count` saturates: at 255, further errors still pulse `frame_err`, but the count stays at 255.
- Reset values:
  - FSM: S_IDLE.
  - `regs`, `wr_strobe`, `wr_addr`, `frame_err`, `err_count`, timeout counter: all 0.
- Reset mid-frame abandons the partial frame with no error pulse. A later byte that is not A5 is then discarded as idle garbage.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Write latency: if the CHK byte is sampled at edge E, then `regs`, `wr_addr` and `wr_strobe` (high for one cycle) are updated at E. They are visible in the cycle after E.
- Error latency: `frame_err` and `err_count` follow the same one-edge latency.
- Timeout latency: with the last byte sampled at edge E and no further bytes, the timeout fires at edge E+TIMEOUT_CYC. `frame_err` is high in the following cycle.
- Simultaneous byte and timeout expiry at the same edge: the byte wins. The counter clears, the byte is processed normally, and there is no error.
- `rst` at the same edge as `received`: reset wins and the byte is ignored.
- Back-to-back `received` (consecutive cycles) is legal. A full frame can therefore complete in 4 cycles.
- A valid CHK byte followed immediately by A5 on the next cycle must start a new frame. S_CHK completes and S_IDLE accepts A5 with no dead cycle.

## Structure
- Package `uart_frame_pkg` holds:
  - `SYNC_BYTE = 8'hA5`
  - `CHK_SEED = 8'hA5`
  - FSM state enum `frame_state_t` (2 bits)
- Sub-module `frame_timer`:
  - Parameter: TIMEOUT_CYC.
  - Inputs: `clk`, `rst`, `clear`, `run`.
  - Output: one-cycle `expired`.
  - Counter width: `$clog2(TIMEOUT_CYC+1)`.
- The FSM, register bank and error counter live in the top module.

## Test plan
- Valid write: bytes A5 01 3C 98 → `regs[1]=8'h3C`; `wr_strobe` high for 1 cycle, one edge after the CHK byte; `wr_addr=1`; no `frame_err`.
- Bad checksum: A5 02 FF 00 (expected CHK 58) → one `frame_err` pulse; `err_count=1`; `regs` unchanged; next frame A5 02 FF 58 writes `regs[2]=8'hFF`.
- Out-of-range address (NREGS=4): A5 07 11 B3 → `frame_err` pulse; `err_count` increments; no `wr_strobe`.
- Timeout (TIMEOUT_CYC=16): A5 00, then 16 idle cycles → `frame_err` in the cycle after edge E+16. Then A5 00 55 F0 → `regs[0]=8'h55`. A separate run with a byte arriving exactly at edge E+16 → no error.
- Idle garbage and reset: 00 FF 13 in idle → no error and no write. A5 03, then `rst` pulse, then 44 → no write and no error, all outputs 0. Back-to-back frames on consecutive cycles → both writes occur.
- Saturation: 260 bad-checksum frames → 260 `frame_err` pulses; `err_count` stops at 255.
